memwb_pipe_stage: RTL
=====================

// Module: memwb_pipe_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage with valid/ready handshake, stall and flush.
//  Sits between data-memory access and register-file writeback. Captures the load data,
//  ALU result, immediate, destination register and WB control bits, and presents them to WB.
//  Also produces the final writeback data and write enable for the register file.
// PARAMETERS
//  DATA_W  32  width of ddata / aluo / imm / wb_data
//  RD_W    5   destination register index width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  flush        in   1       kill all held entries (branch/trap redirect)
//  i_valid      in   1       MEM stage presents a valid instruction
//  o_ready      out  1       stage can accept this cycle
//  i_ddata      in   DATA_W  data-memory read data
//  i_aluo       in   DATA_W  ALU result
//  i_imm        in   DATA_W  immediate (LUI/AUIPC path)
//  i_rd         in   RD_W    destination register
//  i_mem_t_reg  in   1       1: WB takes ddata; 0: WB takes aluo/imm
//  i_reg_w      in   1       instruction writes the register file
//  i_rd_in      in   1       1: WB takes imm instead of aluo (ignored when mem_t_reg=1)
//  o_valid      out  1       WB-side entry valid
//  i_ready      in   1       WB accepts this cycle
//  o_ddata, o_aluo, o_imm   out  DATA_W  registered fields of head entry
//  o_rd         out  RD_W    registered rd of head entry
//  o_mem_t_reg, o_reg_w, o_rd_in  out 1  registered control of head entry
//  o_wb_data    out  DATA_W  mem_t_reg ? ddata : (rd_in ? imm : aluo), combinational from head
//  o_wb_we      out  1       o_valid & i_ready & o_reg_w & (o_rd != 0)
// BEHAVIOUR
//  - Transfer in: i_valid & o_ready at posedge. Transfer out: o_valid & i_ready at posedge.
//  - Latency: an accepted entry appears on o_* the next cycle (1 cycle); throughput 1/cycle.
//  - Reset (rst=1 at posedge): o_valid=0, all o_* data/ctrl fields=0, o_wb_we=0,
//    skid entry invalid; o_ready=1 from the first cycle after reset releases.
//  - Field registers load only on transfer-in; hold their value otherwise (also when invalid).
//  - Flush: at posedge with flush=1, all entries invalidated, o_valid=0 next cycle;
//    an i_valid beat offered in the same cycle is dropped (flush beats accept);
//    flush does not clear field values. rst has priority over flush.
//  - o_wb_we never asserts with o_valid=0 nor for rd=0 (x0 writes suppressed).
//  - Stall (i_ready=0): head entry and all o_* held stable; no entry is lost or duplicated.
// CONFIGURATION
//  - MEMWB_SKID_EN defined: 2-entry skid buffer; o_ready is a flop (no comb path i_ready->o_ready).
//    States: EMPTY (o_valid=0) -> FULL on in; FULL -> EMPTY on out-only, stays FULL on in+out
//    or idle, -> SKID on in while i_ready=0 (beat parked in skid reg, o_ready=0 next cycle);
//    SKID -> FULL on out (skid entry moves to head, o_ready=1 next cycle); flush: any -> EMPTY.
//    o_ready=1 in EMPTY/FULL, 0 in SKID. Beats accepted in order, never reordered.
//  - Not defined: single register; o_ready = i_ready | ~o_valid (combinational);
//    loads when i_valid & o_ready; o_valid cleared on out without in.
// TESTING
//  1 rst=1 two cycles, then idle -> o_valid=0, o_rd=0, o_wb_data=0, o_wb_we=0, o_ready=1.
//  2 i_valid=1, i_aluo=32'h0000_1234, i_rd=5, reg_w=1, mem_t_reg=0, i_ready=1
//    -> next cycle o_valid=1, o_wb_data=32'h1234, o_wb_we=1.
//  3 load: i_ddata=32'hDEAD_BEEF, mem_t_reg=1, rd=0, reg_w=1 -> o_wb_data=DEADBEEF, o_wb_we=0.
//  4 back-to-back rd=1,2,3 with i_ready=0 for 2 cycles mid-stream -> WB sees 1,2,3 once each,
//    in order; with MEMWB_SKID_EN o_ready drops exactly one cycle after the stall begins.
//  5 flush=1 with i_valid=1 (rd=7) while head holds rd=6 -> next cycle o_valid=0, rd=7 never
//    reaches WB, o_ready=1.
//  6 rst=1 while in SKID state -> next cycle o_valid=0, both entries discarded, o_ready=1 after.

Source files
------------

// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline stage: valid/ready handshake, stall, flush, writeback data/enable.
// Optional macro MEMWB_SKID_EN selects a 2-entry skid buffer with a registered o_ready.
module memwb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_ddata,
    input  logic [DATA_W-1:0] i_aluo,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [RD_W-1:0]   i_rd,
    input  logic              i_mem_t_reg,
    input  logic              i_reg_w,
    input  logic              i_rd_in,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_ddata,
    output logic [DATA_W-1:0] o_aluo,
    output logic [DATA_W-1:0] o_imm,
    output logic [RD_W-1:0]   o_rd,
    output logic              o_mem_t_reg,
    output logic              o_reg_w,
    output logic              o_rd_in,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_wb_we
);

    typedef struct packed {
        logic [DATA_W-1:0] ddata;
        logic [DATA_W-1:0] aluo;
        logic [DATA_W-1:0] imm;
        logic [RD_W-1:0]   rd;
        logic              mem_t_reg;
        logic              reg_w;
        logic              rd_in;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [DATA_W-1:0] wb_select(input entry_t e);
        if (e.mem_t_reg) begin
            return e.ddata;
        end else if (e.rd_in) begin
            return e.imm;
        end else begin
            return e.aluo;
        end
    endfunction

    entry_t in_s;
    entry_t head_r;
    logic   valid_r;

    assign in_s = {i_ddata, i_aluo, i_imm, i_rd, i_mem_t_reg, i_reg_w, i_rd_in};

    assign o_valid     = valid_r;
    assign o_ddata     = head_r.ddata;
    assign o_aluo      = head_r.aluo;
    assign o_imm       = head_r.imm;
    assign o_rd        = head_r.rd;
    assign o_mem_t_reg = head_r.mem_t_reg;
    assign o_reg_w     = head_r.reg_w;
    assign o_rd_in     = head_r.rd_in;
    assign o_wb_data   = wb_select(head_r);
    // x0 is hard-wired zero, so writes to it are never issued
    assign o_wb_we     = valid_r & i_ready & head_r.reg_w & (head_r.rd != {RD_W{1'b0}});

`ifdef MEMWB_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    entry_t skid_r;
    logic   ready_r;
    logic   load_head_s;
    logic   load_skid_s;
    logic   move_skid_s;

    assign o_ready = ready_r;

    // Next-state and load-select decode; flush overrides every transition
    always_comb begin
        state_nxt_s = state_r;
        load_head_s = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (i_valid) begin
                        load_head_s = 1'b1;
                        state_nxt_s = FULL;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                FULL: begin
                    if (i_valid && i_ready) begin
                        load_head_s = 1'b1;
                        state_nxt_s = FULL;
                    end else if (i_valid) begin
                        load_skid_s = 1'b1;
                        state_nxt_s = SKID;
                    end else if (i_ready) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                SKID: begin
                    if (i_ready) begin
                        move_skid_s = 1'b1;
                        state_nxt_s = FULL;
                    end else begin
                        state_nxt_s = SKID;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State, handshake flops and entry storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            head_r  <= {ENTRY_W{1'b0}};
            skid_r  <= {ENTRY_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != SKID);
            valid_r <= (state_nxt_s != EMPTY);
            if (load_head_s) begin
                head_r <= in_s;
            end else if (move_skid_s) begin
                head_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_s;
            end
        end
    end
`else
    logic accept_s;
    logic drain_s;

    assign o_ready  = i_ready | ~valid_r;
    assign accept_s = i_valid & o_ready & ~flush;
    assign drain_s  = valid_r & i_ready;

    // Single-entry register; a flushed beat is not loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            head_r  <= {ENTRY_W{1'b0}};
        end else begin
            if (flush) begin
                valid_r <= 1'b0;
            end else if (accept_s) begin
                valid_r <= 1'b1;
            end else if (drain_s) begin
                valid_r <= 1'b0;
            end
            if (accept_s) begin
                head_r <= in_s;
            end
        end
    end
`endif

endmodule
